// File: rtl/gray_step_if.sv
// Command/status bundle between a burst scheduler and the Gray-counter step controller.
interface gray_step_if #(
    parameter int N  = 4,
    parameter int CW = 8
);
    logic          start;
    logic [CW-1:0] count;
    logic          abort;
    logic [N-1:0]  gray_in;
    logic          gc_enable;
    logic          busy;
    logic          done;
    logic [CW-1:0] steps_left;
    logic [N-1:0]  bin_value;
    logic          mismatch;
    logic          err;

    modport master (
        output start, count, abort, gray_in,
        input  gc_enable, busy, done, steps_left, bin_value, mismatch, err
    );

    modport slave (
        input  start, count, abort, gray_in,
        output gc_enable, busy, done, steps_left, bin_value, mismatch, err
    );
endinterface

// File: rtl/gray_step_controller.sv
// Runs a Gray counter for programmed bursts of enable cycles and checks every
// observed code is either a single binary step or a hold, as the enable demands.
module gray_step_controller #(
    parameter int N  = 4,
    parameter int CW = 8
) (
    input  logic        clk,
    input  logic        reset,
    gray_step_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t        state;
    logic          gc_enable_r;
    logic          busy_r;
    logic          done_r;
    logic [CW-1:0] steps_r;

    logic [N-1:0]  bin_r;
    logic          en_q;
    logic          chk_valid;
    logic          mismatch_r;
    logic          err_r;

    logic [N-1:0]  cur_bin;
    logic [N-1:0]  exp_bin;
    logic          mis_det;
    logic          accept;

    function automatic logic [N-1:0] g2b(input logic [N-1:0] g);
        logic [N-1:0] b;
        b[N-1] = g[N-1];
        for (int i = N - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign accept  = (state == IDLE) && bus.start;
    assign cur_bin = g2b(bus.gray_in);
    assign exp_bin = en_q ? bin_r + {{(N-1){1'b0}}, 1'b1} : bin_r;
    assign mis_det = chk_valid && (cur_bin != exp_bin);

    // done is delayed one cycle behind FIN so it follows the last check result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            gc_enable_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            steps_r     <= '0;
        end else begin
            done_r <= (state == FIN);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.count != '0) begin
                            steps_r     <= bus.count;
                            state       <= RUN;
                            gc_enable_r <= 1'b1;
                            busy_r      <= 1'b1;
                        end else begin
                            state <= FIN;
                        end
                    end
                end
                RUN: begin
                    steps_r <= steps_r - {{(CW-1){1'b0}}, 1'b1};
                    if (bus.abort || steps_r == {{(CW-1){1'b0}}, 1'b1}) begin
                        state       <= DRAIN;
                        gc_enable_r <= 1'b0;
                    end
                end
                DRAIN: begin
                    state  <= FIN;
                    busy_r <= 1'b0;
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state       <= IDLE;
                    gc_enable_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    // A detected fault beats the err clear from a simultaneous accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_r      <= '0;
            en_q       <= 1'b0;
            chk_valid  <= 1'b0;
            mismatch_r <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            bin_r      <= cur_bin;
            en_q       <= gc_enable_r;
            chk_valid  <= 1'b1;
            mismatch_r <= mis_det;
            if (mis_det) begin
                err_r <= 1'b1;
            end else if (accept) begin
                err_r <= 1'b0;
            end
        end
    end

    assign bus.gc_enable  = gc_enable_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.steps_left = steps_r;
    assign bus.bin_value  = bin_r;
    assign bus.mismatch   = mismatch_r;
    assign bus.err        = err_r;

endmodule

// File: tb/tb_gray_step_controller.sv
// Directed bench for gray_step_controller driving a behavioural Gray counter.
module tb_gray_step_controller;

    localparam int N  = 4;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gray_step_if #(.N(N), .CW(CW)) bus ();

    gray_step_controller #(.N(N), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Controlled counter; skip_arm makes its 1 -> 2 binary step jump to 3.
    logic [N-1:0] cnt;
    logic         skip_arm;
    always @(posedge clk or posedge reset) begin
        if (reset) cnt <= '0;
        else if (bus.gc_enable) cnt <= (skip_arm && cnt == 4'd1) ? cnt + 4'd2 : cnt + 4'd1;
    end
    assign bus.gray_in = cnt ^ (cnt >> 1);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int cnt;
        int abort_at;
        int skip;
        int en;
        int sl;
        int bin;
        int gray;
        int err;
        int mis;
    } vec_t;

    vec_t vecs[8];

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_cmd(input string tag, input int c, input int abort_at, input int exp_en,
                           input int exp_sl, input int exp_bin, input int exp_gray,
                           input int exp_err, input int exp_mis);
        int en_n = 0, mis_n = 0, done_n = 0, busy_n = 0, run_n = 0, done_idx = -1;
        int sl_d = -1, bin_d = -1, gray_d = -1, err_d = -1;
        int exp_done;
        @(negedge clk);
        bus.start = 1'b1;
        bus.count = CW'(c);
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 600; i++) begin
            bus.abort = 1'b0;
            if (bus.gc_enable) begin
                en_n++;
                run_n++;
                if (run_n == abort_at) bus.abort = 1'b1;
            end
            if (bus.busy) busy_n++;
            if (bus.mismatch) mis_n++;
            if (bus.done) begin
                done_n++;
                if (done_idx < 0) begin
                    done_idx = i;
                    sl_d     = int'(bus.steps_left);
                    bin_d    = int'(bus.bin_value);
                    gray_d   = int'(bus.gray_in);
                    err_d    = int'(bus.err);
                end
            end
            if (done_idx >= 0 && i >= done_idx + 2) break;
            @(negedge clk);
        end
        bus.abort = 1'b0;
        exp_done = (exp_en == 0) ? 1 : exp_en + 2;
        chk({tag, "_done_pulses"}, done_n, 1);
        chk({tag, "_done_latency"}, done_idx, exp_done);
        chk({tag, "_enables"}, en_n, exp_en);
        chk({tag, "_busy_cycles"}, busy_n, (exp_en == 0) ? 0 : exp_en + 1);
        chk({tag, "_steps_left"}, sl_d, exp_sl);
        chk({tag, "_bin_value"}, bin_d, exp_bin);
        chk({tag, "_gray_in"}, gray_d, exp_gray);
        chk({tag, "_err"}, err_d, exp_err);
        chk({tag, "_mismatch_pulses"}, mis_n, exp_mis);
    endtask

    initial begin
        int done_n;
        int en_n;

        vecs[0] = '{5,   0, 0, 5,   0, 5,  7, 0, 0};
        vecs[1] = '{20,  0, 0, 20,  0, 4,  6, 0, 0};
        vecs[2] = '{10,  4, 0, 4,   6, 4,  6, 0, 0};
        vecs[3] = '{0,   0, 0, 0,   0, 0,  0, 0, 0};
        vecs[4] = '{255, 0, 0, 255, 0, 15, 8, 0, 0};
        vecs[5] = '{1,   0, 0, 1,   0, 1,  1, 0, 0};
        vecs[6] = '{3,   1, 0, 1,   2, 1,  1, 0, 0};
        vecs[7] = '{2,   2, 0, 2,   0, 2,  3, 0, 0};

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.count = '0;
        bus.abort = 1'b0;
        skip_arm  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_gc_enable", int'(bus.gc_enable), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_mismatch", int'(bus.mismatch), 0);
        chk("rst_err", int'(bus.err), 0);
        chk("rst_steps_left", int'(bus.steps_left), 0);
        chk("rst_bin_value", int'(bus.bin_value), 0);
        reset = 1'b0;

        for (int v = 0; v < 8; v++) begin
            do_reset();
            skip_arm = vecs[v].skip[0];
            run_cmd($sformatf("v%0d", v), vecs[v].cnt, vecs[v].abort_at, vecs[v].en,
                    vecs[v].sl, vecs[v].bin, vecs[v].gray, vecs[v].err, vecs[v].mis);
            skip_arm = 1'b0;
        end

        // Skipped code: one fault pulse, sticky err, then cleared by the next start.
        do_reset();
        skip_arm = 1'b1;
        run_cmd("skip", 6, 0, 6, 0, 7, 4, 1, 1);
        skip_arm = 1'b0;
        chk("skip_err_sticky", int'(bus.err), 1);
        run_cmd("after_skip", 2, 0, 2, 0, 9, 13, 0, 0);

        // Extra starts while busy, then asynchronous reset mid-burst.
        do_reset();
        @(negedge clk);
        bus.start = 1'b1;
        bus.count = 8'd8;
        @(negedge clk);
        bus.count = 8'd3;
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        chk("midrst_steps_before", int'(bus.steps_left), 6);
        chk("midrst_enable_before", int'(bus.gc_enable), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_gc_enable", int'(bus.gc_enable), 0);
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_steps_left", int'(bus.steps_left), 0);
        chk("midrst_bin_value", int'(bus.bin_value), 0);
        @(negedge clk);
        reset  = 1'b0;
        done_n = 0;
        en_n   = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) done_n++;
            if (bus.gc_enable) en_n++;
        end
        chk("midrst_no_done", done_n, 0);
        chk("midrst_no_enable", en_n, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
